mem_fill: RTL and testbench
===========================

# mem_fill

Parametrised memory fill engine, successor to the fixed 64×2-bit clear block. It writes a programmable address range of an attached single-port memory through the existing `mem_en`/`mem_valid` request handshake. Each word is either a constant or an incrementing pattern. It sits between the top-level init/sequencer logic (`en`/`done` level handshake) and the memory write port. It adds base/length ranging, pattern mode, abort and back-to-back writes.

## Interface
- `ADDR_W`, 6, memory address width; depth is 2^ADDR_W.
- `DATA_W`, 2, memory data width.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  level request; rising to a run is gated by `done` low.
- `base_addr`  in  ADDR_W  first address; captured at start.
- `len`  in  ADDR_W  word count minus one; captured at start.
- `fill_data`  in  DATA_W  constant or pattern seed; captured at start.
- `mode`  in  1  0 = constant, 1 = incrementing; captured at start.
- `mem_en`  out  1  write request; held until accepted.
- `mem_valid`  in  1  memory accept; a write completes on an edge with `mem_en && mem_valid`.
- `mem_addr`  out  ADDR_W  write address.
- `mem_data`  out  DATA_W  write data.
- `busy`  out  1  high in RUN and ABORT.
- `done`  out  1  high in DONE.
- `aborted`  out  1  one-cycle pulse when an abort completes.

## Operation
- States: IDLE, RUN, ABORT, DONE.
- IDLE → RUN: on `en && !done`.
  - Capture `base_addr`, `len`, `fill_data`, `mode`.
  - Set `mem_addr = base_addr` and `mem_data = fill_data`.
  - Set count to 0 and `mem_en` to 1.
- RUN, on accept (`mem_en && mem_valid`):
  - Not last word: `mem_addr += 1` (modulo 2^ADDR_W, wraps to 0); count += 1; `mem_data` = captured data + count (mode 1, modulo 2^DATA_W) or captured data (mode 0). `mem_en` stays 1, so writes can run back-to-back, one per cycle.
  - Last word (count == captured len): `mem_en` → 0, `done` → 1, state → DONE.
- RUN with `en` low, no accept that edge: → ABORT, `mem_en` held at 1.
- RUN with `en` low, accept that edge: → IDLE, `mem_en` → 0, `aborted` pulse.
  - This applies even on the last word: abort wins and `done` stays 0.
- ABORT: hold address, data and `mem_en` until accept, then → IDLE with `aborted` pulse. A started write is never withdrawn.
- DONE: hold `done` = 1 until `en` is sampled low, then → IDLE with `done` = 0. A new run needs `en` low for at least one cycle.
- The `mem_en`/`mem_addr`/`mem_data` outputs are stable whenever `mem_en` is high and no accept occurs.
- `len` = 2^ADDR_W − 1 covers the whole memory; a range crossing the top address wraps.

## Timing
- Reset values: state IDLE; `mem_en` 0, `mem_addr` 0, `mem_data` 0, `busy` 0, `done` 0, `aborted` 0; count 0.
- All outputs are registered. There is no combinational path from `mem_valid` or `en` to any output.
- Start latency: `en` sampled high at edge N puts `mem_en` = 1 and `mem_addr` = base from cycle N+1.
- With `mem_valid` tied high, a run of L = len+1 words takes L cycles of `mem_en`. `done` rises on the cycle after the last accept.
- `done` falls one cycle after `en` is sampled low.
- `aborted` is high for exactly one cycle, the cycle after the completing accept.
- If `rst` asserts mid-run, all outputs clear immediately; the memory may be partially written.

## Structure
- Shared package `mem_fill_pkg` holds:
  - the state enum (IDLE, RUN, ABORT, DONE);
  - mode constants MODE_CONST = 0 and MODE_INCR = 1.
- No sub-module: the data generator is one adder on the captured seed.
- Single flat module, target 150–250 lines.

## Test plan
- Defaults, `base` 0, `len` 63, `fill` 0, mode 0, `mem_valid` tied 1 → 64 consecutive writes to addresses 0..63 with data 0; `done` high on cycle 65 after start; `busy` low.
- `base` 60, `len` 7, mode 1, `fill` 3, `DATA_W` = 2 → addresses 60,61,62,63,0,1,2,3 with data 3,0,1,2,3,0,1,2.
- `mem_valid` high only every third cycle → `mem_addr`/`mem_data` stable while waiting; exactly len+1 accepts; no duplicate or skipped address.
- `en` dropped after 2 accepts while a write is pending, `mem_valid` delayed 4 cycles → `mem_en` stays high until the accept; `aborted` pulses once; `done` never rises.
- `en` held high after `done` → no second run. Drop `en` for 1 cycle, then raise it → a new run starts from the newly captured `base_addr`.
- `rst` asserted mid-run at address 5 → all outputs 0 immediately; after release, state IDLE and a new run starts cleanly.

Source files
------------

// File: rtl/mem_fill_pkg.sv
// Shared types for the memory fill engine: FSM state encoding and fill-mode constants.
package mem_fill_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ABORT,
        DONE
    } state_t;

    localparam logic MODE_CONST = 1'b0;
    localparam logic MODE_INCR  = 1'b1;

endpackage

// File: rtl/mem_fill.sv
// Memory fill engine: writes a base/len address range with constant or incrementing
// data through the mem_en/mem_valid request handshake; supports abort and back-to-back writes.
module mem_fill
    import mem_fill_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              mode,
    output logic              mem_en,
    input  logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    state_t            state;
    logic [ADDR_W-1:0] cap_len;
    logic [DATA_W-1:0] cap_data;
    logic              cap_mode;
    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] next_count;
    logic              accept;

    assign accept     = mem_en && mem_valid;
    assign next_count = count + ADDR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cap_len  <= '0;
            cap_data <= '0;
            cap_mode <= MODE_CONST;
            count    <= '0;
            mem_en   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            aborted <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en && !done) begin
                        state    <= RUN;
                        cap_len  <= len;
                        cap_data <= fill_data;
                        cap_mode <= mode;
                        count    <= '0;
                        mem_addr <= base_addr;
                        mem_data <= fill_data;
                        mem_en   <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    // Abort takes priority over completion, even on the last word.
                    if (!en) begin
                        if (accept) begin
                            state   <= IDLE;
                            mem_en  <= 1'b0;
                            busy    <= 1'b0;
                            aborted <= 1'b1;
                        end else begin
                            state <= ABORT;
                        end
                    end else if (accept) begin
                        if (count == cap_len) begin
                            state  <= DONE;
                            mem_en <= 1'b0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            mem_addr <= mem_addr + ADDR_W'(1);
                            count    <= next_count;
                            mem_data <= (cap_mode == MODE_INCR)
                                      ? cap_data + DATA_W'(next_count)
                                      : cap_data;
                        end
                    end
                end
                ABORT: begin
                    if (accept) begin
                        state   <= IDLE;
                        mem_en  <= 1'b0;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                    end
                end
                DONE: begin
                    if (!en) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_fill.sv
// Directed and randomized checks of mem_fill against an arithmetic model of the expected write sequence.
module tb_mem_fill;

    localparam int AW = 6;
    localparam int DW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] len;
    logic [DW-1:0] fill_data;
    logic          mode;
    logic          mem_en;
    logic          mem_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          busy;
    logic          done;
    logic          aborted;

    int n_assert = 0;
    int n_fail   = 0;
    int en_cycles;
    logic [AW-1:0] wa[$];
    logic [DW-1:0] wd[$];

    mem_fill #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .en(en), .base_addr(base_addr), .len(len),
        .fill_data(fill_data), .mode(mode), .mem_en(mem_en), .mem_valid(mem_valid),
        .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: log an accepted write, then verify outputs held if a request stalled.
    task automatic cycle(input logic vld);
        logic          pe;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        logic          acc;
        mem_valid = vld;
        pe  = mem_en;
        pa  = mem_addr;
        pd  = mem_data;
        acc = pe && vld;
        if (acc) begin
            wa.push_back(pa);
            wd.push_back(pd);
        end
        if (pe) en_cycles++;
        @(posedge clk);
        #1;
        if (pe && !acc) check("hold_stable", {mem_en, mem_addr, mem_data}, {pe, pa, pd});
    endtask

    task automatic start_run(input logic [AW-1:0] b, input logic [AW-1:0] l,
                             input logic [DW-1:0] f, input logic m);
        base_addr = b;
        len       = l;
        fill_data = f;
        mode      = m;
        en        = 1'b1;
        wa.delete();
        wd.delete();
        en_cycles = 0;
        cycle(1'b0);
        check("start_mem_en", mem_en, 1);
        check("start_addr", mem_addr, b);
        check("start_data", mem_data, f);
        check("start_busy", busy, 1);
        // Scramble inputs: the run must use the values captured at start.
        base_addr = AW'($urandom);
        len       = AW'($urandom);
        fill_data = DW'($urandom);
        mode      = ~m;
    endtask

    task automatic check_writes(input logic [AW-1:0] b, input logic [DW-1:0] f,
                                input logic m, input int n);
        check("write_count", wa.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < wa.size()) begin
                check("write_addr", wa[i], (int'(b) + i) % (1 << AW));
                check("write_data", wd[i], m ? (int'(f) + i) % (1 << DW) : int'(f));
            end
        end
    endtask

    // vmode: 0 = mem_valid always high, 1 = every third cycle, 2 = random.
    task automatic do_run(input logic [AW-1:0] b, input logic [AW-1:0] l,
                          input logic [DW-1:0] f, input logic m, input int vmode);
        int   n;
        int   budget;
        logic v;
        start_run(b, l, f, m);
        n      = 0;
        budget = 8 * (int'(l) + 1) + 20;
        while (!done && n < budget) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (n % 3 == 2);
                default: v = 1'($urandom_range(0, 1));
            endcase
            cycle(v);
            check("no_abort_pulse", aborted, 0);
            n++;
        end
        check("done_reached", done, 1);
        if (vmode == 0) begin
            check("run_latency", n, int'(l) + 1);
            check("mem_en_cycles", en_cycles, int'(l) + 1);
        end
        check("done_busy", busy, 0);
        check("done_mem_en", mem_en, 0);
        check_writes(b, f, m, int'(l) + 1);
    endtask

    task automatic finish_run();
        en = 1'b0;
        cycle(1'b0);
        check("done_fall", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        base_addr = '0;
        len       = '0;
        fill_data = '0;
        mode      = 1'b0;
        mem_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {mem_en, mem_addr, mem_data, busy, done, aborted}, 0);
        rst = 1'b0;
        cycle(1'b0);
        check("idle_after_reset", {mem_en, busy, done, aborted}, 0);

        // Whole memory, constant zero, back-to-back writes.
        do_run(6'd0, 6'd63, 2'd0, 1'b0, 0);
        finish_run();

        // Wrapping range with incrementing data.
        do_run(6'd60, 6'd7, 2'd3, 1'b1, 0);
        finish_run();

        // Slow acceptor; stability is checked every stalled cycle.
        do_run(6'd20, 6'd9, 2'd2, 1'b1, 1);

        // en held after done must not start a second run.
        repeat (5) begin
            cycle(1'b1);
            check("done_held", done, 1);
            check("no_rerun", mem_en, 0);
        end
        finish_run();
        do_run(6'd45, 6'd3, 2'd1, 1'b0, 0);
        finish_run();

        // Abort with a pending write: request held until the delayed accept.
        start_run(6'd10, 6'd10, 2'd1, 1'b1);
        cycle(1'b1);
        cycle(1'b1);
        en = 1'b0;
        repeat (4) begin
            cycle(1'b0);
            check("abort_mem_en_held", mem_en, 1);
            check("abort_busy", busy, 1);
            check("abort_no_pulse_yet", aborted, 0);
        end
        cycle(1'b1);
        check("abort_pulse", aborted, 1);
        check("abort_mem_en_off", mem_en, 0);
        check("abort_no_done", done, 0);
        cycle(1'b0);
        check("abort_pulse_width", aborted, 0);
        check("abort_idle", {busy, done}, 0);
        check_writes(6'd10, 2'd1, 1'b1, 3);

        // Abort coinciding with the accept of the only (last) word: abort wins.
        start_run(6'd33, 6'd0, 2'd2, 1'b0);
        en = 1'b0;
        cycle(1'b1);
        check("last_abort_pulse", aborted, 1);
        check("last_abort_no_done", done, 0);
        cycle(1'b0);
        check("last_abort_clear", {aborted, done, busy, mem_en}, 0);
        check_writes(6'd33, 2'd2, 1'b0, 1);

        // Randomized runs.
        for (int k = 0; k < 6; k++) begin
            do_run(AW'($urandom), AW'($urandom_range(0, 15)), DW'($urandom),
                   1'($urandom_range(0, 1)), 2);
            finish_run();
        end

        // Asynchronous reset mid-run at address 5.
        start_run(6'd0, 6'd20, 2'd1, 1'b1);
        for (int n = 0; n < 20 && mem_addr != 6'd5; n++) cycle(1'b1);
        check("reached_addr5", mem_addr, 5);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_clear", {mem_en, mem_addr, mem_data, busy, done, aborted}, 0);
        en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1'b0);
        check("post_reset_idle", {mem_en, busy, done, aborted}, 0);
        do_run(6'd50, 6'd5, 2'd3, 1'b1, 0);
        finish_run();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
